// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package rst_seq_pkg;

    // Sequencer phases: waiting for a stable lock, releasing domains, all released.
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } rst_seq_state_e;

    // The cycle counter must reach the larger of the two wait lengths minus one.
    function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
        int longest;
        longest = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

    // The domain index must address domains 0 .. num_domains-1.
    function automatic int idx_width(input int num_domains);
        return (num_domains > 1) ? $clog2(num_domains) : 1;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds every domain in reset until the clock source has
// been locked for a while, then releases domains one by one in index order.
// A software request (level, acked once per assertion) restarts the sequence.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   lock_i,
    input  logic                   soft_req_i,
    output logic                   soft_ack_o,
    output logic [NUM_DOMAINS-1:0] domain_rst_no,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int IW = idx_width(NUM_DOMAINS);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);

    rst_seq_state_e         state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ack_q, ack_d;
    logic                   armed_q, armed_d;
    logic                   soft_accept;

    // A request only counts once per assertion of soft_req_i.
    assign soft_accept = soft_req_i && armed_q;

    // State, counter, index, domain resets, ack and arm flag all live here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '0;
            ack_q   <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            ack_q   <= ack_d;
            armed_q <= armed_d;
        end
    end

    // Next-state logic; an accepted soft request or a lost lock always wins
    // and drops every domain back into reset on the sampling edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        ack_d   = 1'b0;
        armed_d = armed_q;

        if (!soft_req_i) begin
            armed_d = 1'b1;
        end else if (soft_accept) begin
            armed_d = 1'b0;
        end

        if (soft_accept) begin
            ack_d   = 1'b1;
            state_d = HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    dom_d = '0;
                    if (!lock_i) begin
                        cnt_d = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RELEASE: begin
                    if (!lock_i) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        idx_d   = '0;
                        dom_d   = '0;
                    end else if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        for (int k = 0; k < NUM_DOMAINS; k++) begin
                            if (idx_q == IW'(k)) begin
                                dom_d[k] = 1'b1;
                            end
                        end
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RUN: begin
                    if (!lock_i) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        idx_d   = '0;
                        dom_d   = '0;
                    end else begin
                        dom_d = '1;
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    dom_d   = '0;
                end
            endcase
        end
    end

    assign domain_rst_no = dom_q;
    assign soft_ack_o    = ack_q;
    assign busy_o        = (state_q != RUN);
    assign done_o        = (state_q == RUN);

endmodule
